// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings for the data-memory responder.
//   - access width encodings (WIDTH_*)
//   - responder FSM state type
//   - misaligned(): flags accesses that must be rejected without touching memory
package dm_pkg;

  localparam logic [1:0] WIDTH_WORD = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_BYTE = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Width 3 is illegal and always rejected; bytes can never be misaligned.
  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [1:0] width);
    case (width)
      WIDTH_WORD: return addr_lo != 2'b00;
      WIDTH_HALF: return addr_lo[0];
      WIDTH_BYTE: return 1'b0;
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: combinational byte-lane steering for the data-memory responder.
// Ports:
//   addr_lo_i     byte offset within the word (addr[1:0])
//   width_i       access width (WIDTH_WORD/HALF/BYTE)
//   sign_i        sign-extend extracted half/byte
//   old_word_i    current memory word
//   wdata_i       right-aligned store data
//   merged_word_o old_word_i with the addressed lane(s) replaced by wdata_i
//   rdata_o       addressed lane right-aligned and extended
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  width_i,
  input  logic        sign_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_word_o,
  output logic [31:0] rdata_o
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  always_comb begin
    merged_word_o = old_word_i;
    rdata_o       = '0;
    half_v        = addr_lo_i[1] ? old_word_i[31:16] : old_word_i[15:0];
    byte_v        = old_word_i[{addr_lo_i, 3'b000} +: 8];
    case (width_i)
      WIDTH_WORD: begin
        merged_word_o = wdata_i;
        rdata_o       = old_word_i;
      end
      WIDTH_HALF: begin
        if (addr_lo_i[1]) merged_word_o[31:16] = wdata_i[15:0];
        else              merged_word_o[15:0]  = wdata_i[15:0];
        rdata_o = sign_i ? {{16{half_v[15]}}, half_v} : {16'h0000, half_v};
      end
      WIDTH_BYTE: begin
        merged_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
        rdata_o = sign_i ? {{24{byte_v[7]}}, byte_v} : {24'h000000, byte_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: single-outstanding data-memory responder for the MEM stage.
// Accepts one load/store over req_valid/req_ready, waits WAIT_CYCLES, performs the
// access with lane merging/extraction and returns one response over rsp_valid/rsp_ready.
// Misaligned or illegal-width requests return rsp_err=1, rsp_rdata=0, no write.
// Ports:
//   clk, reset (async, active-high)
//   req_valid/req_ready, req_we, req_addr, req_width, req_sign, req_wdata, req_pc
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err
// Optional: define DM_WRITE_LOG_EN to print one line per performed store.
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_width,
  input  logic        req_sign,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [1:0]  width_q;
  logic        sign_q;
  logic [31:0] wdata_q;
  logic [31:0] pc_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem_q [0:(1 << ADDR_W) - 1];

  logic              in_idle;
  logic              accept;
  logic              req_misal;
  logic              access;
  logic              mem_we;
  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [1:0]        acc_width;
  logic              acc_sign;
  logic [31:0]       acc_wdata;
  logic [31:0]       acc_pc;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       old_word;
  logic [31:0]       merged_word;
  logic [31:0]       extracted;
  logic [31:0]       rsp_rdata_d;
  logic              unused_bits;

  assign in_idle   = (state_q == IDLE);
  assign req_ready = in_idle && !reset;
  // Flops are held in reset anyway, so the internal accept need not see reset.
  assign accept    = req_valid && in_idle;
  assign req_misal = misaligned(req_addr[1:0], req_width);

  // With zero wait states the access happens on the accept edge, so the live
  // request fields feed the datapath while idle; otherwise the registered copy.
  assign acc_we    = in_idle ? req_we    : we_q;
  assign acc_addr  = in_idle ? req_addr  : addr_q;
  assign acc_width = in_idle ? req_width : width_q;
  assign acc_sign  = in_idle ? req_sign  : sign_q;
  assign acc_wdata = in_idle ? req_wdata : wdata_q;
  assign acc_pc    = in_idle ? req_pc    : pc_q;
  assign acc_idx   = acc_addr[ADDR_W+1:2];
  assign old_word  = mem_q[acc_idx];

  assign access = (accept && !req_misal && (WAIT_CYCLES == 0)) ||
                  (state_q == WAIT && cnt_q == 4'd1);
  assign mem_we = access && acc_we;

  assign rsp_rdata_d = acc_we ? '0 : extracted;
  assign unused_bits = ^{acc_addr[31:ADDR_W+2], acc_pc};

  dm_lane_align u_lane_align (
    .addr_lo_i     (acc_addr[1:0]),
    .width_i       (acc_width),
    .sign_i        (acc_sign),
    .old_word_i    (old_word),
    .wdata_i       (acc_wdata),
    .merged_word_o (merged_word),
    .rdata_o       (extracted)
  );

  // The array lives in the reset process only so that a reset coinciding with
  // the access edge suppresses the write; the array itself is never cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      width_q     <= '0;
      sign_q      <= 1'b0;
      wdata_q     <= '0;
      pc_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (mem_we) begin
        mem_q[acc_idx] <= merged_word;
`ifdef DM_WRITE_LOG_EN
        $display("%d@%h: *%h <= %h", $time, acc_pc, {acc_addr[31:2], 2'b00}, merged_word);
`endif
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            width_q <= req_width;
            sign_q  <= req_sign;
            wdata_q <= req_wdata;
            pc_q    <= req_pc;
            if (req_misal) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (WAIT_CYCLES == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= rsp_rdata_d;
            end else begin
              cnt_q   <= 4'(WAIT_CYCLES);
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= rsp_rdata_d;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
Data-memory responder that sits on the far side of the MEM-stage load/store request interface of the pipelined MIPS CPU. It accepts one request at a time over a valid/ready handshake. It performs word, half or byte stores with lane merging, and word, half or byte loads with optional sign extension. It inserts a configurable number of wait states and returns exactly one response per request, also over valid/ready. Misaligned requests are rejected with an error flag and never modify memory.

Parameters:
ADDR_W, 12, word-address bits; the memory holds 2**ADDR_W 32-bit words.
WAIT_CYCLES, 1, extra cycles between request accept and the memory access (0..15).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all control state
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address; bits [ADDR_W+1:2] select the word, higher bits ignored (wrap)
req_width  in  2  0 = word, 1 = half, 2 = byte, 3 = illegal
req_sign  in  1  sign-extend load data (half/byte only)
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_pc  in  32  PC of the issuing instruction, used for the write log only
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_rdata  out  32  load data, right-aligned and extended; 0 for stores and errors
rsp_err  out  1  request was misaligned or illegal

Behaviour:
- Reset values:
  - req_ready = 0 while reset is asserted, 1 in the first cycle after release.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, state = IDLE, wait counter = 0.
  - The memory array is not reset.
- Handshakes:
  - A request is accepted on a clock edge where req_valid && req_ready.
  - A response is consumed on a clock edge where rsp_valid && rsp_ready.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: req_ready = 1.
    - On accept, all req_* fields are registered.
    - If misaligned, go to RESP with err = 1 and no access.
    - Else if WAIT_CYCLES = 0, perform the access on the accept edge and go to RESP.
    - Else load counter = WAIT_CYCLES and go to WAIT.
  - WAIT: req_ready = 0. The counter decrements each cycle. On the edge where the counter is 1, perform the access and go to RESP.
  - RESP: req_ready = 0, rsp_valid = 1. rsp_rdata and rsp_err hold stable until consumed. On consume, go to IDLE and clear rsp_valid.
  - A new request is accepted no earlier than the cycle after consume (no bypass).
- Latency:
  - Accept to rsp_valid is WAIT_CYCLES + 1 cycles.
  - Minimum request-to-request spacing is WAIT_CYCLES + 2 cycles.
- Misaligned conditions:
  - word access with addr[1:0] != 0
  - half access with addr[0] != 0
  - req_width == 3
  - In all cases: rsp_err = 1, rsp_rdata = 0, memory unchanged.
- Store lanes:
  - byte goes to lane addr[1:0] (lane 0 = bits [7:0]).
  - half goes to bits [15:0] when addr[1] = 0, else bits [31:16].
  - Other lanes are preserved.
- Load extraction: select the same lane, right-align it, then sign-extend if req_sign else zero-extend. req_sign is ignored for word loads.
- Memory is updated only in the access cycle; the other FSM states never write.
- Reset mid-operation: an in-flight request is dropped with no write and no response. A store whose access edge coincides with reset assertion is not performed.

Optional Feature:
DM_WRITE_LOG_EN
- When defined: every performed store executes $display("%d@%h: *%h <= %h", $time, pc, word_byte_addr, merged_word).
  - word_byte_addr is the byte address with bits [1:0] cleared.
  - merged_word is the full 32-bit word after lane merging.
  - Misaligned stores print nothing.
- When undefined: no simulation output; RTL is otherwise identical.

Decomposition:
- Package dm_pkg holds:
  - width encodings WIDTH_WORD = 0, WIDTH_HALF = 1, WIDTH_BYTE = 2
  - state encodings IDLE, WAIT, RESP
  - the misalign-check function
- One natural sub-module, dm_lane_align: purely combinational.
  - Inputs: addr[1:0], width, sign, old_word, wdata.
  - Outputs: merged_word and extracted rdata.
  - dm_responder holds the FSM, counter, registers and memory array.

Test Plan:
1. WAIT_CYCLES = 1: store word 0x12345678 @0x10, then load word @0x10 -> rsp_valid 2 cycles after accept, rdata = 0x12345678, err = 0.
2. Store byte 0xAB @0x11 over 0x12345678, then signed load byte @0x11 and unsigned load half @0x12 -> word = 0x1234AB78, rdata = 0xFFFFFFAB, then 0x00001234.
3. Load word @0x12 and store half @0x13 -> err = 1, rdata = 0, word at 0x10 unchanged.
4. Hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0, and a second req_valid is not accepted until the cycle after consume.
5. Assert reset during WAIT of a store 0xDEADBEEF @0x20 -> no response, memory @0x20 unchanged, req_ready = 1 the cycle after release.
6. WAIT_CYCLES = 0 with back-to-back requests and rsp_ready tied to 1 -> one accept every 2 cycles; with DM_WRITE_LOG_EN defined, one log line per store showing the correct pc and merged word.
